// File: rtl/codec_pkg.sv
// Shared definitions for the codec init sequencer: command types, FSM states, width helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package codec_pkg;

  // Command types understood by the I2C configuration writer, in issue order
  localparam logic [3:0] LEFT_LINE_IN  = 4'd0;
  localparam logic [3:0] RIGHT_LINE_IN = 4'd1;
  localparam logic [3:0] LEFT_HP_OUT   = 4'd2;
  localparam logic [3:0] RIGHT_HP_OUT  = 4'd3;
  localparam logic [3:0] ANALOG_PATH   = 4'd4;
  localparam logic [3:0] DIGITAL_PATH  = 4'd5;
  localparam logic [3:0] POWER_DOWN    = 4'd6;
  localparam logic [3:0] DIGITAL_IF    = 4'd7;
  localparam logic [3:0] SAMPLE_CTRL   = 4'd8;
  localparam logic [3:0] ACTIVE        = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    GAP,
    DONE,
    ERROR
  } seq_state_t;

  // Bits needed to hold 0..max_val, never less than one bit
  function automatic int width_for(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/codec_init_sequencer.sv
// Steps the I2C config writer through NUM_CMDS commands with timeout/retry and an idle gap between commands.
// Latency: i_start accepted on an edge drives o_i2c_start high right after that edge; all outputs registered.
// Backpressure: one command in flight; waits for i_i2c_finished (or timeout) before the next; i_start ignored while busy.
module codec_init_sequencer
  import codec_pkg::*;
#(
  parameter int NUM_CMDS       = 10,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRY      = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_i2c_finished,
  output logic       o_i2c_start,
  output logic [3:0] o_i2c_type,
  output logic [3:0] o_cmd_idx,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int CNT_W = (TMR_W > GAP_W) ? TMR_W : GAP_W;
  localparam int RTY_W = width_for(MAX_RETRY);

  // The counter runs down to zero; loading N-1 gives exactly N cycles in the state
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       LAST_IDX = 4'(NUM_CMDS - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  seq_state_t       state, state_n;
  logic [3:0]       idx, idx_n;
  logic [RTY_W-1:0] retry, retry_n;
  // Shared down-counter: WAIT timeout in WAIT, idle gap in GAP; the two never overlap
  logic [CNT_W-1:0] cnt, cnt_n;

  // Next-state logic: command sequencing, timeout/retry bookkeeping and gap timing
  always_comb begin
    state_n = state;
    idx_n   = idx;
    retry_n = retry;
    cnt_n   = cnt;
    unique case (state)
      IDLE, DONE, ERROR: begin
        if (i_start) begin
          state_n = ISSUE;
          idx_n   = '0;
          retry_n = '0;
        end
      end
      ISSUE: begin
        state_n = WAIT;
        cnt_n   = TMO_LOAD;
      end
      WAIT: begin
        // Finish is checked first so it wins over a timeout in the same cycle
        if (i_i2c_finished) begin
          retry_n = '0;
          cnt_n   = GAP_LOAD;
          state_n = (idx >= LAST_IDX) ? DONE : GAP;
        end else if (cnt == '0) begin
          if (retry == RTY_MAX) begin
            state_n = ERROR;
          end else begin
            state_n = GAP;
            retry_n = retry + RTY_W'(1);
            cnt_n   = GAP_LOAD;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_n = ISSUE;
          // retry is cleared only by a finish, so zero here means the last command succeeded
          if (retry == '0) begin
            idx_n = idx + 4'd1;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      idx   <= '0;
      retry <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      retry <= retry_n;
      cnt   <= cnt_n;
    end
  end

  // Outputs registered from the next state so they line up with the state they describe
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_i2c_start <= 1'b0;
      o_i2c_type  <= '0;
      o_cmd_idx   <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      o_i2c_start <= (state_n == ISSUE);
      o_i2c_type  <= idx_n;
      o_cmd_idx   <= idx_n;
      o_busy      <= (state_n inside {ISSUE, WAIT, GAP});
      o_done      <= (state_n == DONE);
      o_error     <= (state_n == ERROR);
    end
  end

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Bench for codec_init_sequencer: writer model, timeline model of expected outputs, per-cycle compare.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_codec_init_sequencer;
  import codec_pkg::*;

  localparam int N    = 10;
  localparam int G    = 16;
  localparam int T    = 64;
  localparam int MR   = 2;
  localparam int MAXC = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       fin = 1'b0;
  logic       i2c_start, busy, done, error;
  logic [3:0] i2c_type, cmd_idx;

  codec_init_sequencer #(
    .NUM_CMDS(N), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T), .MAX_RETRY(MR)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_i2c_finished(fin),
    .o_i2c_start(i2c_start), .o_i2c_type(i2c_type), .o_cmd_idx(cmd_idx),
    .o_busy(busy), .o_done(done), .o_error(error)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; "interval c" is the time right after edge c
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Expected output timeline, one entry per interval
  bit         e_start[MAXC];
  bit         e_busy [MAXC];
  bit         e_done [MAXC];
  bit         e_err  [MAXC];
  bit         e_tv   [MAXC];
  logic [3:0] e_idx  [MAXC];

  // Writer response table: finish delay per (command, attempt); 0 = never finish
  int tab[N][MR+1];
  int att[N];
  int pend[$];
  int log_cyc[$];
  int log_type[$];

  task automatic put(input int c, input bit st, input bit bz, input bit dn, input bit er,
                     input int ix, input bit tv);
    if (c >= 0 && c < MAXC) begin
      e_start[c] = st;
      e_busy[c]  = bz;
      e_done[c]  = dn;
      e_err[c]   = er;
      e_idx[c]   = 4'(ix);
      e_tv[c]    = tv;
    end
  endtask

  // Timeline of a full run accepted at edge acc, built from start-to-start arithmetic
  task automatic model_run(input int acc);
    int s, k, r, d, len;
    bit f;
    s = acc; k = 0; r = 0;
    forever begin
      d   = tab[k][r];
      f   = (d > 0 && d <= T);
      len = f ? d : T;
      for (int c = s; c <= s + len; c++) put(c, c == s, 1, 0, 0, k, 1);
      if (f && k == N - 1) begin
        for (int c = s + len + 1; c < MAXC; c++) put(c, 0, 0, 1, 0, k, 0);
        return;
      end
      if (!f && r == MR) begin
        for (int c = s + len + 1; c < MAXC; c++) put(c, 0, 0, 0, 1, k, 0);
        return;
      end
      for (int c = s + len + 1; c <= s + len + G; c++) put(c, 0, 1, 0, 0, k, 0);
      s = s + len + G + 1;
      if (f) begin k++; r = 0; end
      else r++;
    end
  endtask

  task automatic model_reset(input int from);
    for (int c = from; c < MAXC; c++) put(c, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic set_table(input int d);
    for (int i = 0; i < N; i++) begin
      att[i] = 0;
      for (int j = 0; j <= MR; j++) tab[i][j] = d;
    end
  endtask

  // Writer model: answers each start after the tabled delay with a one-cycle finish
  initial begin
    int t, d;
    forever begin
      @(negedge clk);
      fin = 1'b0;
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (pend[i] == cyc) begin
          fin = 1'b1;
          pend.delete(i);
        end
      end
      if (i2c_start === 1'b1) begin
        t = int'(i2c_type);
        if (t < N && att[t] <= MR) begin
          d = tab[t][att[t]];
          att[t]++;
          if (d > 0) pend.push_back(cyc + d);
        end
      end
    end
  end

  // Per-cycle compare against the timeline, plus a log of every start seen
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      check("i2c_start", i2c_start, e_start[cyc]);
      check("busy",      busy,      e_busy[cyc]);
      check("done",      done,      e_done[cyc]);
      check("error",     error,     e_err[cyc]);
      check("cmd_idx",   cmd_idx,   e_idx[cyc]);
      if (e_tv[cyc]) check("i2c_type", i2c_type, e_idx[cyc]);
    end
    if (i2c_start === 1'b1) begin
      log_cyc.push_back(cyc);
      log_type.push_back(int'(i2c_type));
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_start(input int acc, input bit modeled);
    wait_cyc(acc - 1);
    if (modeled) model_run(acc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_start(input int i, input int c, input int t);
    if (log_cyc.size() <= i) begin
      check("start_present", log_cyc.size(), i + 1);
    end else begin
      check("start_cycle", log_cyc[i], c);
      check("start_type", log_type[i], t);
    end
  endtask

  initial begin
    model_reset(0);
    set_table(40);
    @(negedge clk);
    wait_cyc(3);
    rst_n = 1'b1;

    // Run A: every command finishes after 40 cycles; stray i_start during WAIT of idx 2
    pulse_start(5, 1);
    pulse_start(130, 0);
    wait_cyc(558);
    check("A_done_early", done, 0);
    wait_cyc(559);
    check("A_done", done, 1);
    check("A_busy", busy, 0);
    check_start(0, 5, LEFT_LINE_IN);
    check_start(2, 119, LEFT_HP_OUT);
    check_start(9, 518, ACTIVE);
    check("A_nstarts", log_cyc.size(), 10);

    // Run B: restart from DONE; first start of idx 3 is ignored and times out once
    set_table(40);
    tab[3][0] = 0;
    pulse_start(600, 1);
    check("B_done_cleared", done, 0);
    wait_cyc(1234);
    check("B_done_early", done, 0);
    wait_cyc(1235);
    check("B_done", done, 1);
    check("B_error", error, 0);
    check_start(10, 600, LEFT_LINE_IN);
    check_start(13, 771, RIGHT_HP_OUT);
    check_start(14, 852, RIGHT_HP_OUT);
    check_start(20, 1194, ACTIVE);
    check("B_nstarts", log_cyc.size(), 21);

    // Run C: idx 5 never finishes; three attempts then ERROR
    set_table(40);
    for (int j = 0; j <= MR; j++) tab[5][j] = 0;
    pulse_start(1300, 1);
    wait_cyc(1811);
    check("C_error_early", error, 0);
    wait_cyc(1812);
    check("C_error", error, 1);
    check("C_idx", cmd_idx, 5);
    check("C_done", done, 0);
    check_start(26, 1585, DIGITAL_PATH);
    check_start(27, 1666, DIGITAL_PATH);
    check_start(28, 1747, DIGITAL_PATH);
    wait_cyc(1900);
    check("C_nstarts", log_cyc.size(), 29);
    check("C_error_held", error, 1);

    // Run D: one-cycle reset during WAIT of idx 7; its late finish must be ignored
    set_table(40);
    pulse_start(1950, 1);
    wait_cyc(2360);
    rst_n = 1'b0;
    model_reset(2361);
    @(negedge clk);
    rst_n = 1'b1;
    check("D_busy_rst", busy, 0);
    check("D_idx_rst", cmd_idx, 0);
    check("D_error_rst", error, 0);
    check_start(36, 2349, DIGITAL_IF);
    wait_cyc(2450);
    check("D_nstarts", log_cyc.size(), 37);
    check("D_done", done, 0);

    // Run E: finish coinciding with timeout (also at the retry limit), and a finish arriving after timeout
    set_table(40);
    tab[0][0] = 64;
    tab[1][0] = 65;
    tab[1][1] = 0;
    tab[1][2] = 64;
    pulse_start(2500, 1);
    wait_cyc(3263);
    check("E_done_early", done, 0);
    wait_cyc(3264);
    check("E_done", done, 1);
    check("E_error", error, 0);
    check_start(37, 2500, LEFT_LINE_IN);
    check_start(38, 2581, RIGHT_LINE_IN);
    check_start(39, 2662, RIGHT_LINE_IN);
    check_start(40, 2743, RIGHT_LINE_IN);
    check_start(41, 2824, LEFT_HP_OUT);
    check_start(48, 3223, ACTIVE);
    check("E_nstarts", log_cyc.size(), 49);

    wait_cyc(3300);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
